// File: rtl/pic_priority_resolver.sv
// PIC priority resolver: edge-latched IRR, masking, fixed/rotating priority with nested ISR,
// two-pulse INTA vector delivery and EOI handling. Optional special mask mode: PIC_SPECIAL_MASK_EN.
module pic_priority_resolver #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W = 8,
    localparam int IDX_W = $clog2(NUM_IRQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_done,
    input  logic [NUM_IRQ-1:0]     irq_req,
    input  logic [NUM_IRQ-1:0]     imr,
    input  logic                   rotate_mode,
    input  logic                   aeoi_en,
    input  logic [VEC_W-IDX_W-1:0] vector_base,
    input  logic                   inta,
    input  logic                   eoi_valid,
    input  logic                   eoi_specific,
    input  logic [IDX_W-1:0]       eoi_level,
`ifdef PIC_SPECIAL_MASK_EN
    input  logic                   smm,
`endif
    output logic                   int_out,
    output logic                   vec_valid,
    output logic [VEC_W-1:0]       vec_out,
    output logic [NUM_IRQ-1:0]     isr_out,
    output logic [NUM_IRQ-1:0]     irr_out
);

    typedef enum logic {IDLE, ACK1} state_t;

    state_t               state_q, state_d;
    logic [NUM_IRQ-1:0]   prev_q;
    logic [NUM_IRQ-1:0]   irr_q, irr_d, isr_q, isr_d;
    logic [IDX_W-1:0]     lp_q, lp_d, idx_q, idx_d;
    logic                 spur_q, spur_d, int_q, int_d, vv_q, vv_d;
    logic [VEC_W-1:0]     vec_q, vec_d;

    logic [NUM_IRQ-1:0]   rise, elig, isr_clr, isr_set, irr_clr;
    logic                 win_ok, isr_ok, nested, int_req;
    logic [IDX_W-1:0]     win_idx, isr_idx, win_rank, isr_rank;

    // Scan from lowest to highest priority so the highest-priority set bit is written last.
    function automatic logic [IDX_W:0] pick(input logic [NUM_IRQ-1:0] v, input logic [IDX_W-1:0] lp);
        logic [IDX_W:0]   r;
        logic [IDX_W-1:0] pos;
        r = '0;
        for (int k = NUM_IRQ-1; k >= 0; k--) begin
            pos = lp + IDX_W'(k + 1);
            if (v[pos]) r = {1'b1, pos};
        end
        return r;
    endfunction

    always_comb begin
        rise              = irq_req & ~prev_q;
        elig              = irr_q & ~imr;
        {win_ok, win_idx} = pick(elig, lp_q);
        {isr_ok, isr_idx} = pick(isr_q, lp_q);
        win_rank          = win_idx - lp_q - IDX_W'(1);
        isr_rank          = isr_idx - lp_q - IDX_W'(1);
        nested            = win_ok && (!isr_ok || (win_rank < isr_rank));
`ifdef PIC_SPECIAL_MASK_EN
        int_req           = smm ? |(elig & ~isr_q) : nested;
`else
        int_req           = nested;
`endif
    end

    always_comb begin
        state_d = state_q;
        lp_d    = lp_q;
        idx_d   = idx_q;
        spur_d  = spur_q;
        int_d   = int_req;
        vv_d    = 1'b0;
        vec_d   = vec_q;
        isr_clr = '0;
        isr_set = '0;
        irr_clr = '0;

        if (state_q == IDLE) begin
            if (inta) begin
                state_d = ACK1;
                int_d   = 1'b0;
                if (win_ok) begin
                    idx_d            = win_idx;
                    spur_d           = 1'b0;
                    isr_set[win_idx] = 1'b1;
                    irr_clr[win_idx] = 1'b1;
                end else begin
                    idx_d  = IDX_W'(NUM_IRQ - 1);
                    spur_d = 1'b1;
                end
            end
        end else if (inta) begin
            state_d = IDLE;
            vv_d    = 1'b1;
            vec_d   = {vector_base, idx_q};
            if (aeoi_en && !spur_q) begin
                isr_clr[idx_q] = 1'b1;
                if (rotate_mode) lp_d = idx_q;
            end
        end

        // EOI works on the ISR as it stood before this edge, so a bit set by INTA now survives.
        if (eoi_valid) begin
            if (eoi_specific) begin
                if (isr_q[eoi_level]) begin
                    isr_clr[eoi_level] = 1'b1;
                    if (rotate_mode) lp_d = eoi_level;
                end
            end else if (isr_ok) begin
                isr_clr[isr_idx] = 1'b1;
                if (rotate_mode) lp_d = isr_idx;
            end
        end

        irr_d = (irr_q & ~irr_clr) | rise;
        isr_d = (isr_q & ~isr_clr) | isr_set;

        if (!init_done) begin
            state_d = IDLE;
            irr_d   = '0;
            isr_d   = '0;
            int_d   = 1'b0;
            vv_d    = 1'b0;
            vec_d   = vec_q;
            lp_d    = IDX_W'(NUM_IRQ - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= '0;
            irr_q   <= '0;
            isr_q   <= '0;
            lp_q    <= IDX_W'(NUM_IRQ - 1);
            idx_q   <= '0;
            spur_q  <= 1'b0;
            int_q   <= 1'b0;
            vv_q    <= 1'b0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= irq_req;
            irr_q   <= irr_d;
            isr_q   <= isr_d;
            lp_q    <= lp_d;
            idx_q   <= idx_d;
            spur_q  <= spur_d;
            int_q   <= int_d;
            vv_q    <= vv_d;
            vec_q   <= vec_d;
        end
    end

    assign int_out   = int_q;
    assign vec_valid = vv_q;
    assign vec_out   = vec_q;
    assign isr_out   = isr_q;
    assign irr_out   = irr_q;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Directed bench for pic_priority_resolver: table of per-cycle vectors plus hand sequences,
// covering an 8-channel and a 16-channel instance.
module tb_pic_priority_resolver;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_done;
    logic [7:0] irq_req, imr;
    logic       rotate_mode, aeoi_en, inta, eoi_valid, eoi_specific;
    logic [4:0] vector_base;
    logic [2:0] eoi_level;
    logic       int_out, vec_valid;
    logic [7:0] vec_out, isr_out, irr_out;

    logic [15:0] irq16, isr16, irr16;
    logic        inta16, int16, vv16;
    logic [7:0]  vec16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pic_priority_resolver #(.NUM_IRQ(8), .VEC_W(8)) u_dut (
        .clk(clk), .rst(rst), .init_done(init_done), .irq_req(irq_req), .imr(imr),
        .rotate_mode(rotate_mode), .aeoi_en(aeoi_en), .vector_base(vector_base),
        .inta(inta), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
`ifdef PIC_SPECIAL_MASK_EN
        .smm(1'b0),
`endif
        .int_out(int_out), .vec_valid(vec_valid), .vec_out(vec_out),
        .isr_out(isr_out), .irr_out(irr_out));

    pic_priority_resolver #(.NUM_IRQ(16), .VEC_W(8)) u_dut16 (
        .clk(clk), .rst(rst), .init_done(1'b1), .irq_req(irq16), .imr(16'h0000),
        .rotate_mode(1'b0), .aeoi_en(1'b0), .vector_base(4'b0100),
        .inta(inta16), .eoi_valid(1'b0), .eoi_specific(1'b0), .eoi_level(4'h0),
`ifdef PIC_SPECIAL_MASK_EN
        .smm(1'b0),
`endif
        .int_out(int16), .vec_valid(vv16), .vec_out(vec16),
        .isr_out(isr16), .irr_out(irr16));

    typedef struct {
        logic [7:0] req, msk;
        logic       ack, eoi, spec;
        logic [2:0] lvl;
        logic       rot, aeoi;
        logic       e_int, e_vv;
        logic [7:0] e_vec, e_isr, e_irr;
    } vec_t;

    vec_t tv[37];

    function automatic vec_t mk(logic [7:0] req, logic [7:0] msk, logic ack, logic eoi, logic spec,
                                logic [2:0] lvl, logic rot, logic aeoi, logic e_int, logic e_vv,
                                logic [7:0] e_vec, logic [7:0] e_isr, logic [7:0] e_irr);
        vec_t v;
        v.req = req; v.msk = msk; v.ack = ack; v.eoi = eoi; v.spec = spec; v.lvl = lvl;
        v.rot = rot; v.aeoi = aeoi; v.e_int = e_int; v.e_vv = e_vv;
        v.e_vec = e_vec; v.e_isr = e_isr; v.e_irr = e_irr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; init_done = 1'b1; irq_req = '0; imr = '0; rotate_mode = 1'b0; aeoi_en = 1'b0;
        vector_base = 5'b01000; inta = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = '0;
        irq16 = '0; inta16 = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        // req    imr    ack eoi spc lvl rot aeoi | int vv vec    isr    irr
        tv[0]  = mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        tv[1]  = mk(8'h28, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h28);
        tv[2]  = mk(8'h28, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h28);
        tv[3]  = mk(8'h28, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h08, 8'h20);
        tv[4]  = mk(8'h28, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h08, 8'h20);
        tv[5]  = mk(8'h28, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1, 8'h43, 8'h08, 8'h20);
        tv[6]  = mk(8'h28, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h08, 8'h20);
        tv[7]  = mk(8'h2A, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h08, 8'h22);
        tv[8]  = mk(8'h2A, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h08, 8'h22);
        tv[9]  = mk(8'h2A, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h0A, 8'h20);
        tv[10] = mk(8'h2A, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1, 8'h41, 8'h0A, 8'h20);
        tv[11] = mk(8'h2A, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h08, 8'h20);
        tv[12] = mk(8'h2A, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h08, 8'h20);
        tv[13] = mk(8'h2A, 8'h00, 0, 1, 1, 3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h20);
        tv[14] = mk(8'h2A, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h20);
        tv[15] = mk(8'h2A, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h20, 8'h00);
        tv[16] = mk(8'h2A, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1, 8'h45, 8'h20, 8'h00);
        tv[17] = mk(8'h2A, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        tv[18] = mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        tv[19] = mk(8'h01, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01);
        tv[20] = mk(8'h01, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01);
        tv[21] = mk(8'h01, 8'hFF, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01);
        tv[22] = mk(8'h01, 8'hFF, 1, 0, 0, 0, 0, 0, 0, 1, 8'h47, 8'h00, 8'h01);
        tv[23] = mk(8'h05, 8'h00, 0, 0, 0, 0, 1, 1, 1, 0, 8'h00, 8'h00, 8'h05);
        tv[24] = mk(8'h05, 8'h00, 0, 0, 0, 0, 1, 1, 1, 0, 8'h00, 8'h00, 8'h05);
        tv[25] = mk(8'h05, 8'h00, 1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h01, 8'h04);
        tv[26] = mk(8'h05, 8'h00, 1, 0, 0, 0, 1, 1, 0, 1, 8'h40, 8'h00, 8'h04);
        tv[27] = mk(8'h05, 8'h00, 0, 0, 0, 0, 1, 1, 1, 0, 8'h00, 8'h00, 8'h04);
        tv[28] = mk(8'h05, 8'h00, 1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h04, 8'h00);
        tv[29] = mk(8'h05, 8'h00, 1, 0, 0, 0, 1, 1, 0, 1, 8'h42, 8'h00, 8'h00);
        tv[30] = mk(8'h0F, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h0A);
        tv[31] = mk(8'h0F, 8'h00, 0, 0, 0, 0, 1, 1, 1, 0, 8'h00, 8'h00, 8'h0A);
        tv[32] = mk(8'h0F, 8'h00, 1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h08, 8'h02);
        tv[33] = mk(8'h0F, 8'h00, 1, 0, 0, 0, 1, 1, 0, 1, 8'h43, 8'h00, 8'h02);
        tv[34] = mk(8'h0F, 8'h00, 0, 0, 0, 0, 1, 1, 1, 0, 8'h00, 8'h00, 8'h02);
        tv[35] = mk(8'h0F, 8'h00, 1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h02, 8'h00);
        tv[36] = mk(8'h0F, 8'h00, 1, 0, 0, 0, 1, 1, 0, 1, 8'h41, 8'h00, 8'h00);

        do_reset();
        chk("rst_int", int_out, 0);   chk("rst_vv", vec_valid, 0); chk("rst_vec", vec_out, 0);
        chk("rst_isr", isr_out, 0);   chk("rst_irr", irr_out, 0);
        chk("rst16_isr", isr16, 0);   chk("rst16_irr", irr16, 0);

        for (int i = 0; i < 37; i++) begin
            irq_req = tv[i].req; imr = tv[i].msk; inta = tv[i].ack; eoi_valid = tv[i].eoi;
            eoi_specific = tv[i].spec; eoi_level = tv[i].lvl;
            rotate_mode = tv[i].rot; aeoi_en = tv[i].aeoi;
            step();
            chk($sformatf("v%0d_int", i), int_out, tv[i].e_int);
            chk($sformatf("v%0d_vv", i), vec_valid, tv[i].e_vv);
            if (tv[i].e_vv) chk($sformatf("v%0d_vec", i), vec_out, tv[i].e_vec);
            chk($sformatf("v%0d_isr", i), isr_out, tv[i].e_isr);
            chk($sformatf("v%0d_irr", i), irr_out, tv[i].e_irr);
        end
        inta = 0; eoi_valid = 0; eoi_specific = 0;

        // EOI in the same cycle as the first INTA only clears the older ISR bit
        do_reset();
        irq_req = 8'h10; step(); step(); chk("e_int", int_out, 1);
        inta = 1; step(); step(); chk("e_vec4", vec_out, 8'h44);
        inta = 0; irq_req = 8'h14; step(); step(); chk("e_int2", int_out, 1);
        inta = 1; eoi_valid = 1; step(); chk("e_isr_mix", isr_out, 8'h04);
        eoi_valid = 0; step(); chk("e_vec2", vec_out, 8'h42);
        inta = 0; eoi_valid = 1; eoi_specific = 1; eoi_level = 3'd5; step();
        chk("e_spec_clear_bit", isr_out, 8'h04);
        eoi_specific = 0; step(); chk("e_nonspec", isr_out, 8'h00);
        step(); chk("e_empty", isr_out, 8'h00);
        eoi_valid = 0;

        // Reset between the two INTA pulses
        do_reset();
        irq_req = 8'h08; step(); step(); chk("r_int", int_out, 1);
        inta = 1; step(); chk("r_isr", isr_out, 8'h08);
        inta = 0; irq_req = 8'h00; rst = 1; #2;
        chk("r_async_isr", isr_out, 0);
        step(); chk("r_int0", int_out, 0); chk("r_vv0", vec_valid, 0); chk("r_vec0", vec_out, 0);
        chk("r_irr0", irr_out, 0);
        rst = 0; inta = 1; step(); chk("r_vv_after", vec_valid, 0);
        inta = 0; step(); chk("r_vv_after2", vec_valid, 0);

        // init_done low holds the block idle
        do_reset();
        irq_req = 8'h08; step(); step(); chk("i_int", int_out, 1);
        init_done = 0; step(); chk("i_int0", int_out, 0); chk("i_irr0", irr_out, 0);
        inta = 1; step(); chk("i_isr0", isr_out, 0);
        step(); chk("i_vv0", vec_valid, 0);
        inta = 0; init_done = 1; step(); step();
        chk("i_irr_hist", irr_out, 0); chk("i_int_hist", int_out, 0);

        // 16-channel instance: IRQ11 and IRQ13 together
        do_reset();
        irq16 = 16'h2800; step(); chk("w_irr", irr16, 16'h2800);
        step(); chk("w_int", int16, 1);
        inta16 = 1; step(); chk("w_isr", isr16, 16'h0800); chk("w_irr2", irr16, 16'h2000);
        step(); chk("w_vv", vv16, 1); chk("w_vec", vec16, 8'h4B);
        inta16 = 0; step(); chk("w_vv_pulse", vv16, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pic_priority_resolver.md
Name: pic_priority_resolver

Overview:
Parametrised, fully synchronous successor of the PIC priority resolver. Latches edge-triggered interrupt requests, applies masking, and resolves priority in fixed or automatic-rotating mode with fully nested in-service blocking. Runs the two-pulse INTA acknowledge sequence, delivers the interrupt vector, and handles auto, non-specific and specific EOI. Sits between the control/ICW-OCW decode logic and the data-bus driver of the PIC top level.

Parameters:
NUM_IRQ, 8, number of request channels; power of two, 2..16
VEC_W, 8, vector width; base field is VEC_W-IDX_W bits
IDX_W (localparam), $clog2(NUM_IRQ), channel index width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
init_done  input  1  initialisation sequence complete; low holds the block idle
irq_req  input  NUM_IRQ  raw request lines, already synchronised to clk
imr  input  NUM_IRQ  mask, 1 = channel masked
rotate_mode  input  1  1 = automatic rotating priority, 0 = fixed (IR0 highest)
aeoi_en  input  1  1 = auto-EOI at end of second INTA
vector_base  input  VEC_W-IDX_W  upper vector bits
inta  input  1  one-cycle pulse per CPU INTA strobe
eoi_valid  input  1  one-cycle EOI command strobe
eoi_specific  input  1  1 = specific EOI, 0 = non-specific
eoi_level  input  IDX_W  channel cleared by specific EOI
int_out  output  1  interrupt request to CPU
vec_valid  output  1  one-cycle pulse, vec_out valid
vec_out  output  VEC_W  {vector_base, index}
isr_out  output  NUM_IRQ  in-service register
irr_out  output  NUM_IRQ  request register

Behaviour:
- Reset: int_out=0, vec_valid=0, vec_out=0, isr_out=0, irr_out=0, state IDLE, irq_req edge history=0, lowest-priority pointer lp=NUM_IRQ-1 (IR0 highest).
- IRR: bit i set on rising edge of irq_req[i] (registered compare with previous value); cleared when that channel is accepted into ISR. Set and clear on the same bit in the same cycle: set wins.
- Priority order: channel (lp+1) mod NUM_IRQ highest, wrapping to lp lowest. Fixed mode: lp stays NUM_IRQ-1.
- Eligible = irr & ~imr. Winner = highest-priority eligible bit. int_out (registered, 1-cycle latency) = 1 when winner exists and ranks strictly above the highest-priority ISR bit (or ISR empty).
- FSM: IDLE -> ACK1 on inta. At that edge: if winner exists, freeze index=winner, set ISR[index], clear IRR[index]; otherwise spurious: index=NUM_IRQ-1, ISR unchanged.
- ACK1 -> IDLE on second inta: vec_out={vector_base,index}, vec_valid=1 for one cycle. If aeoi_en and not spurious: clear ISR[index]; if also rotate_mode: lp=index.
- Extra inta in ACK1 is the second pulse; no third-pulse state. inta while init_done=0 ignored.
- int_out drops the cycle after the first inta and re-evaluates from the next cycle.
- EOI (any state, eoi_valid): non-specific clears highest-priority set ISR bit; specific clears ISR[eoi_level]. rotate_mode and a bit actually cleared: lp=cleared index. EOI with ISR empty: no change. EOI same cycle as ISR set by first inta: clear applied to pre-existing bits only; new bit stays set.
- init_done low: state forced IDLE, IRR and ISR cleared, int_out=0, lp reset to NUM_IRQ-1; edge history still tracks irq_req.
- Reset mid-acknowledge: immediate return to reset values; no vec_valid.

Optional Feature:
PIC_SPECIAL_MASK_EN: when defined, adds input smm (1 bit). smm=1 disables nesting: int_out = winner exists among irr & ~imr & ~isr regardless of ISR priority; EOI unchanged. Undefined: port absent, always fully nested.

Test Plan:
- Fixed, NUM_IRQ=8, vector_base=5'b01000: rise IRQ3 and IRQ5 same cycle -> int_out=1; two inta -> vec_out=8'h43, isr_out=8'h08, irr_out=8'h20.
- ISR=8'h08, raise IRQ5 -> int_out stays 0; raise IRQ1 -> int_out=1, ack gives vec_out=8'h41, isr_out=8'h0A.
- Non-specific EOI with isr_out=8'h0A -> isr_out=8'h08; specific EOI level 3 -> 8'h00.
- rotate_mode=1, aeoi_en=1: IRQ2 and IRQ0 pending, ack -> index 0 served, lp=0; next ack -> index 2, lp=2; isr_out stays 0.
- inta with all requests masked (imr=8'hFF) -> vec_out=8'h47, isr_out unchanged, no int_out.
- rst asserted between the two inta pulses -> all outputs 0, no vec_valid; NUM_IRQ=16 build repeats scenario 1 on IRQ11/IRQ13 -> vec_out low nibble 4'hB.
